systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Upstream stage of the weight-stationary systolic array. It loads one weight column per beat into the array, with the array's ctrl lines asserted on each beat. It then streams feature vectors into the array rows with a diagonal skew, so that row r is delayed r cycles. A small input FIFO decouples the feature source and allows features to be prefetched during weight load. The block counts vectors, drains the pipeline and pulses done.

Parameters:
WIDTH, 8, bits per weight/feature element
ROWS, 2, array rows (elements per vector)
COLS, 2, array columns (weight beats per job)
DEPTH, 4, feature FIFO entries (power of 2, >=2)

Ports:
clk_in  in  1  clock
nrst_in  in  1  reset, asynchronous, active-low
start_in  in  1  job start pulse; sampled in IDLE only
num_vec_in  in  16  feature vectors in job; sampled with start_in
w_valid_in  in  1  weight beat valid
w_ready_out  out  1  weight beat accepted when valid&ready
w_data_in  in  ROWS*WIDTH  one weight column, row r at [r*WIDTH+:WIDTH]
f_valid_in  in  1  feature vector valid
f_ready_out  out  1  feature accepted when valid&ready
f_data_in  in  ROWS*WIDTH  feature vector, row r at [r*WIDTH+:WIDTH]
arr_ctrl_out  out  ROWS*COLS  all-ones on weight-load cycles, else zero
arr_weight_out  out  ROWS*WIDTH  registered weight beat to array
arr_feature_out  out  ROWS*WIDTH  skewed feature rows to array
arr_feat_valid_out  out  ROWS  per-row valid, skewed like the data
busy_out  out  1  high in any state but IDLE
done_out  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, FIFO empty, counters 0, skew registers 0.
- FSM states IDLE, LOAD_W, STREAM, DRAIN.
  - IDLE -> LOAD_W on start_in. start_in in any other state is ignored.
- LOAD_W:
  - w_ready_out=1.
  - Each accepted beat registers to arr_weight_out, and arr_ctrl_out = all-ones on the following cycle only. arr_ctrl_out is 0 on bubble cycles, and arr_weight_out holds its last value.
  - After the COLS-th beat is accepted: go to STREAM if num_vec != 0, else go to DRAIN.
- f_ready_out = (state is LOAD_W or STREAM) & !fifo_full & (accepted_cnt < num_vec).
  - fifo_full is registered, so a push is never granted into a full FIFO, even if a pop happens in the same cycle.
- STREAM:
  - Pop one entry per cycle whenever the FIFO is non-empty. Pops never happen outside STREAM.
  - A popped vector enters skew stage 0. Row r passes through r additional registers.
  - A vector popped at edge k drives row r on arr_feature_out from edge k+r, with arr_feat_valid_out[r]=1.
  - With an empty FIFO, a vector accepted at edge e is popped at e+1, so row r appears at edge e+1+r.
  - Empty FIFO in STREAM: a bubble is inserted, with data 0 and valid 0.
  - After the num_vec-th pop, go to DRAIN.
- DRAIN:
  - Zeros shift through the skew registers.
  - Counter runs ROWS-1+COLS cycles. On exit, done_out=1 for one cycle and the FSM returns to IDLE.
- Counters are 16-bit and saturate at num_vec; no wrap is possible.
- Reset asserted mid-job: immediate abort. The FIFO and skew contents are discarded and no done_out is produced.
- Array contract: the array holds its weights while arr_ctrl_out=0.

Decomposition:
- Package systolic_pkg:
  - state enum feeder_state_t {IDLE, LOAD_W, STREAM, DRAIN}
  - localparam CNT_W=16
  - helper function for drain length ROWS-1+COLS
- Sub-module feeder_fifo:
  - Synchronous FIFO, WIDTH*ROWS x DEPTH.
  - Registered full/empty, with push/pop ports.
- Skew registers and FSM live in systolic_feeder.

Test Plan:
All scenarios use ROWS=2, COLS=2, WIDTH=8, DEPTH=4.
- Reset: nrst_in=0 with random inputs -> all outputs 0, w_ready_out=0, f_ready_out=0, busy_out=0. Release -> IDLE, no done_out.
- Weight load: start_in, num_vec=3; beats 0x0201 then 0x0403 with one bubble between -> arr_weight_out=0x0201 with ctrl=4'b1111 for one cycle, ctrl=0 in the bubble cycle, then 0x0403 with ctrl=4'b1111. w_ready_out drops after the 2nd beat.
- Skew stream: features 0x0101, 0x0202, 0x0303 back-to-back in STREAM -> row0 shows 01, 02, 03 on three consecutive cycles; row1 shows the same values one cycle later. Valid bits track the data. done_out pulses 3 cycles after the last pop, then busy_out=0.
- Prefetch/backpressure: num_vec=6; hold w_valid_in=0 in LOAD_W and offer 6 vectors -> 4 accepted, then f_ready_out=0. After the weights complete, 6 vectors emerge in order with no drops.
- Zero-length job: num_vec=0 -> f_ready_out never asserts. After 2 weight beats, DRAIN runs 3 cycles, then done_out fires.
- Abort: assert nrst_in mid-STREAM -> outputs zero immediately. A new job after release behaves as a fresh job. A start_in pulse while busy_out=1 is ignored.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } feeder_state_t;

  localparam int unsigned CNT_W = 16;

  // Cycles needed for the last skewed row to clear the array after the final pop.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
    return rows - 1 + cols;
  endfunction

endpackage

// File: rtl/systolic_feeder_fifo.sv
// Synchronous feature FIFO with registered full/empty flags.
module feeder_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             nrst_in,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             full_q;
  logic             empty_q;

  always_comb begin
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/systolic_feeder.sv
// Weight loader and diagonally skewed feature streamer for a weight-stationary array.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  nrst_in,
  input  logic                  start_in,
  input  logic [15:0]           num_vec_in,
  input  logic                  w_valid_in,
  output logic                  w_ready_out,
  input  logic [ROWS*WIDTH-1:0] w_data_in,
  input  logic                  f_valid_in,
  output logic                  f_ready_out,
  input  logic [ROWS*WIDTH-1:0] f_data_in,
  output logic [ROWS*COLS-1:0]  arr_ctrl_out,
  output logic [ROWS*WIDTH-1:0] arr_weight_out,
  output logic [ROWS*WIDTH-1:0] arr_feature_out,
  output logic [ROWS-1:0]       arr_feat_valid_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int unsigned VW = ROWS * WIDTH;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_len(ROWS, COLS) - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(COLS - 1);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [VW-1:0]    weight_q, weight_d;
  logic [ROWS*COLS-1:0] ctrl_q, ctrl_d;
  logic             done_q, done_d;

  logic             w_ready;
  logic             f_ready;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [VW-1:0]    fifo_rdata;

  feeder_fifo #(
    .WIDTH (VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .nrst_in (nrst_in),
    .push_i  (push),
    .data_i  (f_data_in),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    w_ready     = (state_q == LOAD_W);
    f_ready     = ((state_q == LOAD_W) || (state_q == STREAM)) && !fifo_full &&
                  (acc_cnt_q < num_vec_q);
    push        = f_valid_in && f_ready;
    pop         = (state_q == STREAM) && !fifo_empty;
    state_d     = state_q;
    num_vec_d   = num_vec_q;
    acc_cnt_d   = acc_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    weight_d    = weight_q;
    ctrl_d      = '0;
    done_d      = 1'b0;

    if (push) acc_cnt_d = acc_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d    = LOAD_W;
          num_vec_d  = num_vec_in;
          acc_cnt_d  = '0;
          pop_cnt_d  = '0;
          beat_cnt_d = '0;
        end
      end
      LOAD_W: begin
        if (w_valid_in) begin
          weight_d   = w_data_in;
          ctrl_d     = '1;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == BEAT_LAST) begin
            state_d     = (num_vec_q != '0) ? STREAM : DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      STREAM: begin
        if (pop) begin
          pop_cnt_d = pop_cnt_q + CNT_W'(1);
          if (pop_cnt_q + CNT_W'(1) == num_vec_q) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + CNT_W'(1);
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q     <= IDLE;
      num_vec_q   <= '0;
      acc_cnt_q   <= '0;
      pop_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      weight_q    <= '0;
      ctrl_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_vec_q   <= num_vec_d;
      acc_cnt_q   <= acc_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      weight_q    <= weight_d;
      ctrl_q      <= ctrl_d;
      done_q      <= done_d;
    end
  end

  // Row r owns a chain of r+1 registers; stage 0 of every row loads on the pop edge.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int unsigned R = r;
    logic [WIDTH-1:0] data_q [R+1];
    logic             vld_q  [R+1];

    always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
        for (int unsigned j = 0; j <= R; j++) begin
          data_q[j] <= '0;
          vld_q[j]  <= 1'b0;
        end
      end else begin
        data_q[0] <= pop ? fifo_rdata[R*WIDTH +: WIDTH] : '0;
        vld_q[0]  <= pop;
        for (int unsigned j = 1; j <= R; j++) begin
          data_q[j] <= data_q[j-1];
          vld_q[j]  <= vld_q[j-1];
        end
      end
    end

    assign arr_feature_out[R*WIDTH +: WIDTH] = data_q[R];
    assign arr_feat_valid_out[R]             = vld_q[R];
  end

  assign w_ready_out    = w_ready;
  assign f_ready_out    = f_ready;
  assign arr_ctrl_out   = ctrl_q;
  assign arr_weight_out = weight_q;
  assign busy_out       = (state_q != IDLE);
  assign done_out       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: queue-based reference model plus directed literal checks.
module tb_systolic_feeder;

  localparam int unsigned W  = 8;
  localparam int unsigned R  = 2;
  localparam int unsigned C  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned VW = R * W;

  logic            clk_in     = 1'b0;
  logic            nrst_in    = 1'b1;
  logic            start_in   = 1'b0;
  logic [15:0]     num_vec_in = '0;
  logic            w_valid_in = 1'b0;
  logic [VW-1:0]   w_data_in  = '0;
  logic            f_valid_in = 1'b0;
  logic [VW-1:0]   f_data_in  = '0;
  logic            w_ready_out;
  logic            f_ready_out;
  logic [R*C-1:0]  arr_ctrl_out;
  logic [VW-1:0]   arr_weight_out;
  logic [VW-1:0]   arr_feature_out;
  logic [R-1:0]    arr_feat_valid_out;
  logic            busy_out;
  logic            done_out;

  systolic_feeder #(
    .WIDTH (W),
    .ROWS  (R),
    .COLS  (C),
    .DEPTH (D)
  ) dut (
    .clk_in             (clk_in),
    .nrst_in            (nrst_in),
    .start_in           (start_in),
    .num_vec_in         (num_vec_in),
    .w_valid_in         (w_valid_in),
    .w_ready_out        (w_ready_out),
    .w_data_in          (w_data_in),
    .f_valid_in         (f_valid_in),
    .f_ready_out        (f_ready_out),
    .f_data_in          (f_data_in),
    .arr_ctrl_out       (arr_ctrl_out),
    .arr_weight_out     (arr_weight_out),
    .arr_feature_out    (arr_feature_out),
    .arr_feat_valid_out (arr_feat_valid_out),
    .busy_out           (busy_out),
    .done_out           (done_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 weight load, 2 stream, 3 drain.
  typedef struct packed { logic v; logic [VW-1:0] d; } slot_t;
  slot_t         hist [R];
  int            phase, mnum, macc, mpop, mbeats, mdrain;
  logic [VW-1:0] mq [$];
  logic [R*C-1:0] e_ctrl;
  logic [VW-1:0] e_weight;
  logic          e_done;

  task automatic model_reset();
    phase = 0; mnum = 0; macc = 0; mpop = 0; mbeats = 0; mdrain = 0;
    mq.delete();
    e_ctrl = '0; e_weight = '0; e_done = 1'b0;
    for (int r = 0; r < R; r++) hist[r] = '0;
  endtask

  task automatic model_step();
    int            sz;
    bit            fr, pop;
    logic [VW-1:0] popped;
    sz     = mq.size();
    fr     = (phase == 1 || phase == 2) && sz < D && macc < mnum;
    pop    = (phase == 2) && sz > 0;
    popped = pop ? mq[0] : '0;
    e_ctrl = '0;
    e_done = 1'b0;
    case (phase)
      0: if (start_in) begin
        phase = 1; mnum = int'(num_vec_in); macc = 0; mpop = 0; mbeats = 0;
      end
      1: if (w_valid_in) begin
        e_weight = w_data_in;
        e_ctrl   = '1;
        mbeats++;
        if (mbeats == C) begin
          phase  = (mnum != 0) ? 2 : 3;
          mdrain = 0;
        end
      end
      2: if (pop) begin
        mpop++;
        if (mpop == mnum) begin
          phase = 3; mdrain = 0;
        end
      end
      default: begin
        mdrain++;
        if (mdrain == R - 1 + C) begin
          phase = 0; e_done = 1'b1;
        end
      end
    endcase
    if (pop) void'(mq.pop_front());
    if (f_valid_in && fr) begin
      mq.push_back(f_data_in);
      macc++;
    end
    for (int r = R - 1; r > 0; r--) hist[r] = hist[r-1];
    hist[0] = {pop, popped};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge nrst_in);
      if (!nrst_in) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    logic [VW-1:0] ef;
    logic [R-1:0]  ev;
    logic          efr;
    forever begin
      @(negedge clk_in);
      for (int r = 0; r < R; r++) begin
        ev[r]         = hist[r].v;
        ef[r*W +: W]  = hist[r].d[r*W +: W];
      end
      efr = (phase == 1 || phase == 2) && (mq.size() < D) && (macc < mnum);
      chk("w_ready",    w_ready_out,        phase == 1);
      chk("f_ready",    f_ready_out,        efr);
      chk("busy",       busy_out,           phase != 0);
      chk("done",       done_out,           e_done);
      chk("ctrl",       arr_ctrl_out,       e_ctrl);
      chk("weight",     arr_weight_out,     e_weight);
      chk("feature",    arr_feature_out,    ef);
      chk("feat_valid", arr_feat_valid_out, ev);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic start_job(input int n);
    start_in   = 1'b1;
    num_vec_in = 16'(n);
    tick();
    start_in   = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {w_ready_out, f_ready_out, arr_ctrl_out, arr_weight_out, arr_feature_out,
             arr_feat_valid_out, busy_out, done_out}, '0);
  endtask

  function automatic logic [VW-1:0] vec(input int k);
    return {8'(8'hA0 + k), 8'(8'h50 + k)};
  endfunction

  initial begin
    int            k, beats, nrow0;
    bit            wr, fr, got_done;
    logic [7:0]    row0 [$];
    logic [7:0]    row1 [$];

    // Reset with random inputs
    #1 nrst_in = 1'b0;
    repeat (3) begin
      start_in   = 1'($urandom);
      num_vec_in = 16'($urandom);
      w_valid_in = 1'($urandom);
      w_data_in  = VW'($urandom);
      f_valid_in = 1'($urandom);
      f_data_in  = VW'($urandom);
      tick();
      chk_all_zero("reset_outputs");
    end
    start_in = 0; w_valid_in = 0; f_valid_in = 0; num_vec_in = '0;
    nrst_in = 1'b1;
    tick(); tick();
    chk("reset_release_idle", {busy_out, done_out}, 2'b00);

    // Weight load with one bubble, then skewed stream of three vectors
    start_job(3);
    chk("load_w_ready", w_ready_out, 1'b1);
    chk("load_busy", busy_out, 1'b1);
    w_valid_in = 1'b1; w_data_in = 16'h0201;
    tick();
    chk("beat0", {arr_ctrl_out, arr_weight_out}, {4'b1111, 16'h0201});
    w_valid_in = 1'b0;
    tick();
    chk("bubble", {arr_ctrl_out, arr_weight_out}, {4'b0000, 16'h0201});
    w_valid_in = 1'b1; w_data_in = 16'h0403;
    tick();
    chk("beat1", {arr_ctrl_out, arr_weight_out}, {4'b1111, 16'h0403});
    chk("w_ready_drop", w_ready_out, 1'b0);
    w_valid_in = 1'b0;
    f_valid_in = 1'b1; f_data_in = 16'h0101;
    tick();
    chk("skew_e1", arr_feat_valid_out, 2'b00);
    f_data_in = 16'h0202;
    tick();
    chk("skew_e2", {arr_feat_valid_out, arr_feature_out}, {2'b01, 16'h0001});
    f_data_in = 16'h0303;
    tick();
    f_valid_in = 1'b0;
    chk("skew_e3", {arr_feat_valid_out, arr_feature_out}, {2'b11, 16'h0102});
    tick();
    chk("skew_e4", {arr_feat_valid_out, arr_feature_out}, {2'b11, 16'h0203});
    tick();
    chk("skew_e5", {arr_feat_valid_out, arr_feature_out, done_out}, {2'b10, 16'h0300, 1'b0});
    tick();
    chk("drain_done_early", done_out, 1'b0);
    tick();
    chk("done_pulse", {done_out, busy_out}, 2'b10);
    tick();
    chk("done_one_cycle", done_out, 1'b0);

    // Prefetch during weight load, FIFO backpressure
    start_job(6);
    k = 0;
    w_valid_in = 1'b0;
    repeat (6) begin
      f_valid_in = 1'b1; f_data_in = vec(k);
      fr = f_ready_out;
      tick();
      if (fr) k++;
    end
    chk("prefetch_accepted", k, 4);
    chk("prefetch_ready_low", f_ready_out, 1'b0);
    beats = 0; got_done = 0;
    for (int t = 0; t < 40 && !got_done; t++) begin
      w_valid_in = (beats < 2); w_data_in = VW'($urandom);
      f_valid_in = (k < 6);     f_data_in = vec(k);
      wr = w_ready_out; fr = f_ready_out;
      tick();
      if (wr && w_valid_in) beats++;
      if (fr && f_valid_in) k++;
      if (arr_feat_valid_out[0]) row0.push_back(arr_feature_out[7:0]);
      if (done_out) got_done = 1;
    end
    w_valid_in = 0; f_valid_in = 0;
    chk("prefetch_done", got_done, 1'b1);
    chk("prefetch_total", k, 6);
    nrow0 = row0.size();
    chk("prefetch_count", nrow0, 6);
    for (int i = 0; i < 6 && i < nrow0; i++) chk("prefetch_order", row0[i], 8'(8'h50 + i));

    // Zero-length job
    start_job(0);
    f_valid_in = 1'b1; f_data_in = 16'hFFFF;
    w_valid_in = 1'b1; w_data_in = 16'h1234;
    repeat (2) begin
      chk("zero_f_ready", f_ready_out, 1'b0);
      tick();
    end
    chk("zero_weight", {arr_ctrl_out, arr_weight_out}, {4'b1111, 16'h1234});
    w_valid_in = 1'b0;
    tick(); tick();
    chk("zero_no_early_done", done_out, 1'b0);
    tick();
    chk("zero_done", {done_out, busy_out}, 2'b10);
    f_valid_in = 1'b0;

    // Abort mid-stream, then a fresh job with an ignored start pulse
    start_job(5);
    w_valid_in = 1'b1; w_data_in = 16'h5A5A;
    tick(); tick();
    w_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_valid_in = 1'b1; f_data_in = vec(i + 8);
      tick();
    end
    f_valid_in = 1'b0;
    nrst_in = 1'b0;
    #1 chk_all_zero("abort_outputs");
    tick();
    nrst_in = 1'b1;
    tick();
    chk("abort_idle", {busy_out, done_out}, 2'b00);
    start_job(1);
    start_in = 1'b1; num_vec_in = 16'd7;
    tick();
    start_in = 1'b0;
    w_valid_in = 1'b1; w_data_in = 16'h7788;
    tick(); tick();
    w_valid_in = 1'b0;
    f_valid_in = 1'b1; f_data_in = 16'hBEEF;
    tick();
    f_valid_in = 1'b0;
    got_done = 0;
    row0.delete(); row1.delete();
    for (int t = 0; t < 20 && !got_done; t++) begin
      tick();
      if (arr_feat_valid_out[0]) row0.push_back(arr_feature_out[7:0]);
      if (arr_feat_valid_out[1]) row1.push_back(arr_feature_out[15:8]);
      if (done_out) got_done = 1;
    end
    chk("fresh_done", got_done, 1'b1);
    chk("fresh_rows", {8'(row0.size()), 8'(row1.size())}, 16'h0101);
    if (row0.size() == 1 && row1.size() == 1)
      chk("fresh_data", {row1[0], row0[0]}, 16'hBEEF);

    // Randomized traffic against the model
    for (int t = 0; t < 1500; t++) begin
      start_in   = ($urandom % 8) == 0;
      num_vec_in = 16'($urandom % 10);
      w_valid_in = 1'($urandom);
      w_data_in  = VW'($urandom);
      f_valid_in = ($urandom % 3) != 0;
      f_data_in  = VW'($urandom);
      if (($urandom % 400) == 0) begin
        nrst_in = 1'b0;
        tick();
        nrst_in = 1'b1;
      end
      tick();
    end
    start_in = 1'b0; w_valid_in = 1'b1; f_valid_in = 1'b1;
    for (int t = 0; t < 100 && busy_out; t++) tick();
    chk("final_idle", busy_out, 1'b0);
    w_valid_in = 1'b0; f_valid_in = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
